// File: rtl/jaa_stream_xlate_pkg.sv
// Shared opcode values, A32 encoding fields, helper encoders and the translator state enum.
// All encoders take the condition field so the parameterised COND reaches every word.
package jaa_stream_xlate_pkg;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        EMIT      = 2'd2
    } state_t;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_ICONST_M1 = 8'h02;
    localparam logic [7:0] OP_ICONST_5  = 8'h08;
    localparam logic [7:0] OP_BIPUSH    = 8'h10;
    localparam logic [7:0] OP_ILOAD     = 8'h15;
    localparam logic [7:0] OP_ILOAD_0   = 8'h1A;
    localparam logic [7:0] OP_ILOAD_3   = 8'h1D;
    localparam logic [7:0] OP_ISTORE    = 8'h36;
    localparam logic [7:0] OP_ISTORE_0  = 8'h3B;
    localparam logic [7:0] OP_ISTORE_3  = 8'h3E;
    localparam logic [7:0] OP_POP       = 8'h57;
    localparam logic [7:0] OP_DUP       = 8'h59;
    localparam logic [7:0] OP_SWAP      = 8'h5F;
    localparam logic [7:0] OP_IADD      = 8'h60;
    localparam logic [7:0] OP_ISUB      = 8'h64;

    // Instruction bodies below the condition field; r1/r2 scratch, sp = r13.
    localparam logic [27:0] A_PUSH_R1  = 28'h92D0002;
    localparam logic [27:0] A_PUSH_R2  = 28'h92D0004;
    localparam logic [27:0] A_POP_R1   = 28'h8BD0002;
    localparam logic [27:0] A_POP_R12  = 28'h8BD0006;
    localparam logic [27:0] A_ADD_R112 = 28'h0811002;
    localparam logic [27:0] A_SUB_R121 = 28'h0421001;
    localparam logic [27:0] A_ADD_SP4  = 28'h28DD004;
    localparam logic [19:0] A_MOV_R1   = 20'h3A010;
    localparam logic [19:0] A_MVN_R1   = 20'h3E010;
    localparam logic [7:0]  A_LDR      = 8'h59;
    localparam logic [7:0]  A_STR      = 8'h58;

    function automatic logic op_has_arg(input logic [7:0] op);
        return op inside {OP_BIPUSH, OP_ILOAD, OP_ISTORE};
    endfunction

    function automatic logic op_supported(input logic [7:0] op);
        return op inside {OP_NOP, [OP_ICONST_M1:OP_ICONST_5], OP_BIPUSH, OP_ILOAD,
                          [OP_ILOAD_0:OP_ILOAD_3], OP_ISTORE, [OP_ISTORE_0:OP_ISTORE_3],
                          OP_POP, OP_DUP, OP_SWAP, OP_IADD, OP_ISUB};
    endfunction

    function automatic logic [31:0] enc(input logic [3:0] cond, input logic [27:0] body);
        return {cond, body};
    endfunction

    function automatic logic [31:0] enc_imm(input logic [3:0] cond, input logic [19:0] pfx,
                                            input logic [7:0] imm);
        return {cond, pfx, imm};
    endfunction

    function automatic logic [31:0] enc_ldst(input logic [3:0] cond, input logic [7:0] pfx,
                                             input logic [3:0] base, input logic [7:0] idx,
                                             input int unsigned shift);
        logic [11:0] off;
        off = {4'b0, idx} << shift;
        return {cond, pfx, base, 4'h1, off};
    endfunction

endpackage

// File: rtl/jaa_stream_xlate_if.sv
// Bytecode-in / ARM-word-out handshake bundle plus error reporting.
// slave = translator side, master = fetch buffer / instruction sink side.
interface jaa_stream_xlate_if;
    logic [7:0]  bc_byte;
    logic        bc_valid;
    logic        bc_ready;
    logic [31:0] arm_instruction;
    logic        arm_valid;
    logic        arm_ready;
    logic        err_pulse;
    logic [7:0]  err_opcode;

    modport slave (
        input  bc_byte, bc_valid, arm_ready,
        output bc_ready, arm_instruction, arm_valid, err_pulse, err_opcode
    );

    modport master (
        output bc_byte, bc_valid, arm_ready,
        input  bc_ready, arm_instruction, arm_valid, err_pulse, err_opcode
    );
endinterface

// File: rtl/jaa_stream_xlate_uop_rom.sv
// Combinational expansion table: (opcode, arg, step) -> ARM word and last-word flag.
// Unknown opcodes return a zero word marked last; the FSM never asks for them.
module jaa_stream_xlate_uop_rom
    import jaa_stream_xlate_pkg::*;
#(
    parameter logic [3:0]  COND        = 4'hE,
    parameter int unsigned BASE_REG    = 11,
    parameter int unsigned LOCAL_SHIFT = 2
) (
    input  logic [7:0]  i_opcode,
    input  logic [7:0]  i_arg,
    input  logic [1:0]  i_step,
    output logic [31:0] o_word,
    output logic        o_last
);
    localparam logic [3:0] RB = 4'(BASE_REG);

    logic [7:0] w_idx;

    always_comb begin
        o_word = '0;
        o_last = 1'b1;
        w_idx  = '0;
        case (i_opcode) inside
            [OP_ICONST_M1:OP_ICONST_5]: begin
                if (i_step == 2'd0) begin
                    o_last = 1'b0;
                    o_word = (i_opcode == OP_ICONST_M1) ? enc_imm(COND, A_MVN_R1, 8'h00)
                                                        : enc_imm(COND, A_MOV_R1, i_opcode - 8'd3);
                end else begin
                    o_word = enc(COND, A_PUSH_R1);
                end
            end
            OP_BIPUSH: begin
                if (i_step == 2'd0) begin
                    o_last = 1'b0;
                    // negative bytes fit an 8-bit immediate only as MVN of the complement
                    o_word = i_arg[7] ? enc_imm(COND, A_MVN_R1, ~i_arg)
                                      : enc_imm(COND, A_MOV_R1, i_arg);
                end else begin
                    o_word = enc(COND, A_PUSH_R1);
                end
            end
            OP_ILOAD, [OP_ILOAD_0:OP_ILOAD_3]: begin
                w_idx = (i_opcode == OP_ILOAD) ? i_arg : i_opcode - OP_ILOAD_0;
                if (i_step == 2'd0) begin
                    o_last = 1'b0;
                    o_word = enc_ldst(COND, A_LDR, RB, w_idx, LOCAL_SHIFT);
                end else begin
                    o_word = enc(COND, A_PUSH_R1);
                end
            end
            OP_ISTORE, [OP_ISTORE_0:OP_ISTORE_3]: begin
                w_idx = (i_opcode == OP_ISTORE) ? i_arg : i_opcode - OP_ISTORE_0;
                if (i_step == 2'd0) begin
                    o_last = 1'b0;
                    o_word = enc(COND, A_POP_R1);
                end else begin
                    o_word = enc_ldst(COND, A_STR, RB, w_idx, LOCAL_SHIFT);
                end
            end
            OP_IADD, OP_ISUB: begin
                o_last = (i_step >= 2'd2);
                case (i_step)
                    2'd0:    o_word = enc(COND, A_POP_R12);
                    2'd1:    o_word = enc(COND, (i_opcode == OP_IADD) ? A_ADD_R112 : A_SUB_R121);
                    default: o_word = enc(COND, A_PUSH_R1);
                endcase
            end
            OP_POP: o_word = enc(COND, A_ADD_SP4);
            OP_DUP: begin
                o_last = (i_step >= 2'd2);
                o_word = (i_step == 2'd0) ? enc(COND, A_POP_R1) : enc(COND, A_PUSH_R1);
            end
            OP_SWAP: begin
                o_last = (i_step >= 2'd2);
                case (i_step)
                    2'd0:    o_word = enc(COND, A_POP_R12);
                    2'd1:    o_word = enc(COND, A_PUSH_R1);
                    default: o_word = enc(COND, A_PUSH_R2);
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/jaa_stream_xlate.sv
// Streaming bytecode-to-A32 translator: byte handshake at N gives first word valid at N+1, one word/cycle.
// Output word is registered and held while arm_ready is low; bytes are refused while words are pending.
module jaa_stream_xlate
    import jaa_stream_xlate_pkg::*;
#(
    parameter logic [3:0]  COND        = 4'hE,
    parameter int unsigned BASE_REG    = 11,
    parameter int unsigned LOCAL_SHIFT = 2
) (
    input logic               clk,
    input logic               reset,
    jaa_stream_xlate_if.slave bus
);
    state_t      r_state, w_state_nxt;
    logic [7:0]  r_op, w_op_nxt, r_arg, w_arg_nxt, r_err_op, w_err_op_nxt;
    logic [1:0]  r_step, w_step_nxt;
    logic [31:0] r_word, w_word_nxt;
    logic        r_last, w_last_nxt, r_valid, w_valid_nxt;
    logic        r_err_pulse, w_err_pulse_nxt, r_bc_ready, w_bc_ready_nxt;
    logic [7:0]  w_rom_op, w_rom_arg;
    logic [1:0]  w_rom_step;
    logic [31:0] w_rom_word;
    logic        w_rom_last, w_bc_hs, w_arm_hs;

    assign w_bc_hs  = bus.bc_valid & r_bc_ready;
    assign w_arm_hs = r_valid & bus.arm_ready;

    // The ROM looks at the incoming byte while fetching, and at the next step while emitting.
    always_comb begin
        w_rom_op   = r_op;
        w_rom_arg  = r_arg;
        w_rom_step = 2'(r_step + 2'd1);
        if (r_state == FETCH_OP) begin
            w_rom_op   = bus.bc_byte;
            w_rom_step = 2'd0;
        end else if (r_state == FETCH_ARG) begin
            w_rom_arg  = bus.bc_byte;
            w_rom_step = 2'd0;
        end
    end

    jaa_stream_xlate_uop_rom #(
        .COND(COND), .BASE_REG(BASE_REG), .LOCAL_SHIFT(LOCAL_SHIFT)
    ) u_rom (
        .i_opcode(w_rom_op), .i_arg(w_rom_arg), .i_step(w_rom_step),
        .o_word(w_rom_word), .o_last(w_rom_last)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_arg_nxt       = r_arg;
        w_step_nxt      = r_step;
        w_word_nxt      = r_word;
        w_last_nxt      = r_last;
        w_valid_nxt     = r_valid;
        w_err_pulse_nxt = 1'b0;
        w_err_op_nxt    = r_err_op;
        unique case (r_state)
            FETCH_OP: if (w_bc_hs) begin
                w_op_nxt = bus.bc_byte;
                if (!op_supported(bus.bc_byte)) begin
                    w_err_pulse_nxt = 1'b1;
                    w_err_op_nxt    = bus.bc_byte;
                end else if (op_has_arg(bus.bc_byte)) begin
                    w_state_nxt = FETCH_ARG;
                end else if (bus.bc_byte != OP_NOP) begin
                    w_step_nxt  = 2'd0;
                    w_word_nxt  = w_rom_word;
                    w_last_nxt  = w_rom_last;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = EMIT;
                end
            end
            FETCH_ARG: if (w_bc_hs) begin
                w_arg_nxt   = bus.bc_byte;
                w_step_nxt  = 2'd0;
                w_word_nxt  = w_rom_word;
                w_last_nxt  = w_rom_last;
                w_valid_nxt = 1'b1;
                w_state_nxt = EMIT;
            end
            EMIT: if (w_arm_hs) begin
                if (r_last) begin
                    w_valid_nxt = 1'b0;
                    w_step_nxt  = 2'd0;
                    w_state_nxt = FETCH_OP;
                end else begin
                    w_step_nxt = w_rom_step;
                    w_word_nxt = w_rom_word;
                    w_last_nxt = w_rom_last;
                end
            end
            default: w_state_nxt = FETCH_OP;
        endcase
        w_bc_ready_nxt = (w_state_nxt != EMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= FETCH_OP;
            r_op        <= '0;
            r_arg       <= '0;
            r_step      <= '0;
            r_word      <= '0;
            r_last      <= 1'b0;
            r_valid     <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_op    <= '0;
            r_bc_ready  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_arg       <= w_arg_nxt;
            r_step      <= w_step_nxt;
            r_word      <= w_word_nxt;
            r_last      <= w_last_nxt;
            r_valid     <= w_valid_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_err_op    <= w_err_op_nxt;
            r_bc_ready  <= w_bc_ready_nxt;
        end
    end

    assign bus.bc_ready        = r_bc_ready;
    assign bus.arm_instruction = r_word;
    assign bus.arm_valid       = r_valid;
    assign bus.err_pulse       = r_err_pulse;
    assign bus.err_opcode      = r_err_op;
endmodule

// File: tb/tb_jaa_stream_xlate.sv
// Randomised bench for jaa_stream_xlate against a queue-based model of the expansion rules.
module tb_jaa_stream_xlate;
    logic clk = 1'b0;
    logic reset;

    jaa_stream_xlate_if bus();

    jaa_stream_xlate #(.COND(4'hE), .BASE_REG(11), .LOCAL_SHIFT(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] PUSH1 = 32'hE92D0002;
    localparam logic [31:0] PUSH2 = 32'hE92D0004;
    localparam logic [31:0] POP1  = 32'hE8BD0002;
    localparam logic [31:0] POP12 = 32'hE8BD0006;

    typedef struct { logic [31:0] w; bit last; } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         pend_op = -1;
    logic [7:0] exp_err_op = 8'h00;
    bit         err_due, first_due;
    int         ready_mode = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic bit takes_arg(input int b);
        return b == 'h10 || b == 'h15 || b == 'h36;
    endfunction

    function automatic bit known(input int b);
        return b == 0 || (b >= 2 && b <= 8) || takes_arg(b) || (b >= 'h1A && b <= 'h1D) ||
               (b >= 'h3B && b <= 'h3E) || b == 'h57 || b == 'h59 || b == 'h5F ||
               b == 'h60 || b == 'h64;
    endfunction

    task automatic put(input logic [31:0] w, input bit last);
        exp_t e;
        e.w = w;
        e.last = last;
        exp_q.push_back(e);
        first_due = 1'b1;
    endtask

    // Expected A32 words for one complete bytecode, COND=E, frame base r11, offsets idx*4.
    task automatic expand(input int op, input int arg);
        int idx;
        if (op >= 2 && op <= 8) begin
            if (op == 2) put(32'hE3E01000, 0);
            else         put(32'hE3A01000 + 32'(op - 3), 0);
            put(PUSH1, 1);
        end else if (op == 'h10) begin
            if (arg < 128) put(32'hE3A01000 + 32'(arg), 0);
            else           put(32'hE3E01000 + 32'(255 - arg), 0);
            put(PUSH1, 1);
        end else if (op == 'h15 || (op >= 'h1A && op <= 'h1D)) begin
            idx = (op == 'h15) ? arg : op - 'h1A;
            put(32'hE59B1000 + 32'(idx * 4), 0);
            put(PUSH1, 1);
        end else if (op == 'h36 || (op >= 'h3B && op <= 'h3E)) begin
            idx = (op == 'h36) ? arg : op - 'h3B;
            put(POP1, 0);
            put(32'hE58B1000 + 32'(idx * 4), 1);
        end else if (op == 'h60) begin
            put(POP12, 0); put(32'hE0811002, 0); put(PUSH1, 1);
        end else if (op == 'h64) begin
            put(POP12, 0); put(32'hE0421001, 0); put(PUSH1, 1);
        end else if (op == 'h57) begin
            put(32'hE28DD004, 1);
        end else if (op == 'h59) begin
            put(POP1, 0); put(PUSH1, 0); put(PUSH1, 1);
        end else if (op == 'h5F) begin
            put(POP12, 0); put(PUSH1, 0); put(PUSH2, 1);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int v;
        v = int'(b);
        if (pend_op >= 0) begin
            expand(pend_op, v);
            pend_op = -1;
        end else if (!known(v)) begin
            err_due = 1'b1;
            exp_err_op = b;
        end else if (takes_arg(v)) begin
            pend_op = v;
        end else if (v != 0) begin
            expand(v, 0);
        end
    endtask

    // One clock: drive arm_ready, score handshakes, advance, then check cycle-level rules.
    task automatic tick();
        bit bc_hs, arm_hs, stall, next_due, ready_due;
        logic [31:0] held;
        exp_t e;
        next_due = 1'b0;
        ready_due = 1'b0;
        case (ready_mode)
            0:       bus.arm_ready = 1'b1;
            1:       bus.arm_ready = !bus.arm_ready;
            2:       bus.arm_ready = 1'($urandom_range(0, 1));
            default: bus.arm_ready = 1'b0;
        endcase
        bc_hs  = bus.bc_valid && bus.bc_ready;
        arm_hs = bus.arm_valid && bus.arm_ready;
        stall  = bus.arm_valid && !bus.arm_ready;
        held   = bus.arm_instruction;
        if (bus.arm_valid) chk("bc_ready_low_in_emit", 32'(bus.bc_ready), 0);
        if (arm_hs) begin
            chk("word_was_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("arm_word", bus.arm_instruction, e.w);
                if (e.last) ready_due = 1'b1;
                else        next_due = 1'b1;
            end
        end
        if (bc_hs) model_byte(bus.bc_byte);
        @(posedge clk);
        #1;
        chk("err_pulse", 32'(bus.err_pulse), 32'(err_due));
        chk("err_opcode", 32'(bus.err_opcode), 32'(exp_err_op));
        if (first_due) chk("first_word_latency", 32'(bus.arm_valid), 1);
        if (next_due)  chk("next_word_valid", 32'(bus.arm_valid), 1);
        if (stall) begin
            chk("stall_valid_held", 32'(bus.arm_valid), 1);
            chk("stall_word_held", bus.arm_instruction, held);
        end
        if (ready_due) begin
            chk("bc_ready_return", 32'(bus.bc_ready), 1);
            chk("valid_drop_after_last", 32'(bus.arm_valid), 0);
        end
        err_due = 1'b0;
        first_due = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc = 1'b0;
        bus.bc_byte = b;
        bus.bc_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            acc = bus.bc_ready;
            tick();
        end
        chk("bc_accept", 32'(acc), 1);
        bus.bc_valid = 1'b0;
        bus.bc_byte = 8'($urandom);
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0 && !bus.arm_valid) break;
            tick();
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 0);
        chk("drain_valid_low", 32'(bus.arm_valid), 0);
    endtask

    logic [7:0] ops [24] = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                             8'h10, 8'h15, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h36, 8'h3B,
                             8'h3C, 8'h3D, 8'h3E, 8'h57, 8'h59, 8'h5F, 8'h60, 8'h64};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op;
        reset = 1'b1;
        bus.bc_valid = 1'b0;
        bus.bc_byte = 8'h00;
        bus.arm_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bc_ready", 32'(bus.bc_ready), 0);
        chk("rst_arm_valid", 32'(bus.arm_valid), 0);
        chk("rst_arm_instruction", bus.arm_instruction, 0);
        chk("rst_err_pulse", 32'(bus.err_pulse), 0);
        chk("rst_err_opcode", 32'(bus.err_opcode), 0);
        reset = 1'b0;
        tick();
        chk("bc_ready_after_reset", 32'(bus.bc_ready), 1);

        ready_mode = 0;
        send_byte(8'h05); drain();
        send_byte(8'h10); send_byte(8'hFF); drain();
        send_byte(8'h10); send_byte(8'h7F); drain();
        send_byte(8'h15); send_byte(8'h05); send_byte(8'h36); send_byte(8'hFF); drain();
        ready_mode = 1;
        send_byte(8'h60); drain();
        ready_mode = 0;
        send_byte(8'hCA); send_byte(8'h60); drain();

        // Reset while swap's second word is stalled on the output.
        send_byte(8'h5F);
        tick();
        ready_mode = 3;
        tick();
        chk("swap_word2_present", bus.arm_instruction, PUSH1);
        reset = 1'b1;
        #1;
        chk("midrst_arm_valid", 32'(bus.arm_valid), 0);
        chk("midrst_arm_instruction", bus.arm_instruction, 0);
        chk("midrst_bc_ready", 32'(bus.bc_ready), 0);
        chk("midrst_err_opcode", 32'(bus.err_opcode), 0);
        exp_q.delete();
        pend_op = -1;
        exp_err_op = 8'h00;
        err_due = 1'b0;
        first_due = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready_mode = 0;
        tick();
        chk("bc_ready_after_midrst", 32'(bus.bc_ready), 1);
        send_byte(8'h5F); drain();

        for (int i = 0; i < 250; i++) begin
            ready_mode = 2;
            if ($urandom_range(0, 7) == 0) op = 8'($urandom);
            else                           op = ops[$urandom_range(0, 23)];
            if ($urandom_range(0, 3) == 0) tick();
            send_byte(op);
            if (pend_op >= 0) send_byte(8'($urandom));
        end
        ready_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
